// File: rtl/sha1_pad_if.sv
// Byte-in / 512-bit-block-out bus for the SHA-1 message padder.
interface sha1_pad_if;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned BLK_W  = 512;

    logic              in_valid_i;
    logic [BYTE_W-1:0] in_data_i;
    logic              in_last_i;
    logic              in_ready_o;
    logic              blk_valid_o;
    logic [BLK_W-1:0]  block_o;
    logic              blk_last_o;
    logic              blk_ready_i;

    // Padder side
    modport slave (
        input  in_valid_i, in_data_i, in_last_i, blk_ready_i,
        output in_ready_o, blk_valid_o, block_o, blk_last_o
    );

    // Byte source / block sink side
    modport master (
        output in_valid_i, in_data_i, in_last_i, blk_ready_i,
        input  in_ready_o, blk_valid_o, block_o, blk_last_o
    );
endinterface

// File: rtl/sha1_pad.sv
// SHA-1 message padder: packs bytes into 512-bit blocks, appends 0x80,
// zero fill and the 64-bit big-endian bit length.
module sha1_pad #(
    parameter int unsigned LEN_W = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    sha1_pad_if.slave   bus
);
    localparam int unsigned BLK_W = 512;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        EMIT_DATA = 2'd1,
        EMIT_PAD  = 2'd2,
        EMIT_LEN  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [BLK_W-1:0]   buf_q, buf_d;
    logic [LEN_W-1:0]   n_q, n_d;
    logic               pad_pend_q, pad_pend_d;
    logic               blk_last_q, blk_last_d;
    logic               in_ready_q, in_ready_d;
    logic               blk_valid_q, blk_valid_d;

    logic [LEN_W-1:0]   n_inc;
    logic [5:0]         k;
    logic [5:0]         p;
    logic [8:0]         byte_sh;
    logic [8:0]         pad_sh;
    logic [63:0]        len_cur;
    logic [63:0]        len_inc;
    logic               accept;

    // State, buffer, counter and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FILL;
            buf_q       <= '0;
            n_q         <= '0;
            pad_pend_q  <= 1'b0;
            blk_last_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            blk_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            n_q         <= n_d;
            pad_pend_q  <= pad_pend_d;
            blk_last_q  <= blk_last_d;
            in_ready_q  <= in_ready_d;
            blk_valid_q <= blk_valid_d;
        end
    end

    // Next-state: byte packing, padding insertion and block sequencing
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        n_d        = n_q;
        pad_pend_d = pad_pend_q;
        blk_last_d = blk_last_q;

        n_inc   = n_q + LEN_W'(1);
        k       = n_q[5:0];
        p       = n_inc[5:0];
        byte_sh = {6'd63 - k, 3'b000};
        pad_sh  = {6'd63 - p, 3'b000};
        len_cur = 64'({n_q, 3'b000});
        len_inc = 64'({n_inc, 3'b000});
        accept  = bus.in_valid_i && in_ready_q;

        case (state_q)
            FILL: begin
                if (accept) begin
                    buf_d = buf_q | (BLK_W'(bus.in_data_i) << byte_sh);
                    n_d   = n_inc;
                    if (bus.in_last_i) begin
                        if (p == 6'd0) begin
                            // Full data block first; padding gets its own block
                            state_d    = EMIT_DATA;
                            pad_pend_d = 1'b1;
                            blk_last_d = 1'b0;
                        end else begin
                            buf_d   = buf_d | (BLK_W'(8'h80) << pad_sh);
                            state_d = EMIT_PAD;
                            if (p <= 6'd55) begin
                                buf_d[63:0] = len_inc;
                                blk_last_d  = 1'b1;
                            end else begin
                                blk_last_d  = 1'b0;
                            end
                        end
                    end else if (k == 6'd63) begin
                        state_d    = EMIT_DATA;
                        pad_pend_d = 1'b0;
                        blk_last_d = 1'b0;
                    end
                end
            end
            EMIT_DATA: begin
                if (bus.blk_ready_i) begin
                    if (pad_pend_q) begin
                        buf_d      = {8'h80, 440'd0, len_cur};
                        blk_last_d = 1'b1;
                        pad_pend_d = 1'b0;
                        state_d    = EMIT_PAD;
                    end else begin
                        buf_d   = '0;
                        state_d = FILL;
                    end
                end
            end
            EMIT_PAD: begin
                if (bus.blk_ready_i) begin
                    if (blk_last_q) begin
                        buf_d      = '0;
                        n_d        = '0;
                        blk_last_d = 1'b0;
                        state_d    = FILL;
                    end else begin
                        buf_d      = {448'd0, len_cur};
                        blk_last_d = 1'b1;
                        state_d    = EMIT_LEN;
                    end
                end
            end
            EMIT_LEN: begin
                if (bus.blk_ready_i) begin
                    buf_d      = '0;
                    n_d        = '0;
                    blk_last_d = 1'b0;
                    state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase

        in_ready_d  = (state_d == FILL);
        blk_valid_d = (state_d != FILL);
    end

    assign bus.in_ready_o  = in_ready_q;
    assign bus.blk_valid_o = blk_valid_q;
    assign bus.block_o     = buf_q;
    assign bus.blk_last_o  = blk_last_q;
endmodule

// File: tb/tb_sha1_pad.sv
// Scoreboard bench for sha1_pad: directed messages, stall and reset cases.
module tb_sha1_pad;
    typedef struct packed {
        logic [511:0] blk;
        logic         last;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   n_cons = 0;
    exp_t exp_q[$];

    localparam logic [511:0] ABC_BLK = {32'h61626380, 416'd0, 64'h18};
    localparam logic [511:0] INC_BLK =
        512'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f_20212223_24252627_28292a2b_2c2d2e2f_30313233_34353637_38393a3b_3c3d3e3f;

    sha1_pad_if bus ();

    sha1_pad #(.LEN_W(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pop and compare on every consumed block
    always @(negedge clk) begin
        if (rst_n && bus.blk_valid_o && bus.blk_ready_i) begin
            exp_t e;
            n_cons++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_block got=%h last=%b", bus.block_o, bus.blk_last_o);
            end else begin
                e = exp_q.pop_front();
                if (bus.block_o !== e.blk) begin
                    bad++;
                    $display("FAIL block got=%h want=%h", bus.block_o, e.blk);
                end
                total++;
                if (bus.blk_last_o !== e.last) begin
                    bad++;
                    $display("FAIL blk_last got=%b want=%b", bus.blk_last_o, e.last);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, act, want);
        end
    endtask

    task automatic chkw(input string name, input logic [511:0] act, input logic [511:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    task automatic chki(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    task automatic push(input logic [511:0] b, input logic l);
        exp_t e;
        e.blk  = b;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int t = 0;
        while (!bus.in_ready_o && t < 200) begin
            tick();
            t++;
        end
        if (t >= 200) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout got=0 want=1");
        end
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = d;
        bus.in_last_i  = l;
        tick();
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
    endtask

    // mode 0: all 0x00, mode 1: byte i = i, mode 2: 0xA5 without last
    task automatic send_msg(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = (mode == 1) ? 8'(i) : ((mode == 2) ? 8'hA5 : 8'h00);
            send_byte(d, (mode != 2) && (i == n - 1));
        end
    endtask

    task automatic send_abc();
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            tick();
            t++;
        end
        chki("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        int c0;
        rst_n           = 1'b0;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = 8'h00;
        bus.in_last_i   = 1'b0;
        bus.blk_ready_i = 1'b1;
        repeat (3) tick();
        chk1("rst_in_ready", bus.in_ready_o, 1'b0);
        chk1("rst_blk_valid", bus.blk_valid_o, 1'b0);
        chk1("rst_blk_last", bus.blk_last_o, 1'b0);
        chkw("rst_block", bus.block_o, 512'd0);
        rst_n = 1'b1;
        tick();
        chk1("post_rst_in_ready", bus.in_ready_o, 1'b1);

        // "abc"
        push(ABC_BLK, 1'b1);
        send_abc();
        drain();

        // 55 zero bytes: single block
        push({440'd0, 8'h80, 64'h1B8}, 1'b1);
        send_msg(55, 0);
        drain();

        // 56 zero bytes: pad block then length block
        push({448'd0, 8'h80, 56'd0}, 1'b0);
        push({448'd0, 64'h1C0}, 1'b1);
        send_msg(56, 0);
        drain();

        // 64 bytes 0..63: data block then pad+length block
        push(INC_BLK, 1'b0);
        push({8'h80, 440'd0, 64'h200}, 1'b1);
        send_msg(64, 1);
        drain();
        chk1("idle_in_ready", bus.in_ready_o, 1'b1);

        // Downstream stall for 10 cycles
        bus.blk_ready_i = 1'b0;
        push(ABC_BLK, 1'b1);
        send_abc();
        c0 = n_cons;
        for (int i = 0; i < 10; i++) begin
            chk1("stall_valid", bus.blk_valid_o, 1'b1);
            chk1("stall_in_ready", bus.in_ready_o, 1'b0);
            chk1("stall_last", bus.blk_last_o, 1'b1);
            chkw("stall_block", bus.block_o, ABC_BLK);
            tick();
        end
        chki("stall_cons", n_cons, c0);
        bus.blk_ready_i = 1'b1;
        tick();
        chki("release_cons", n_cons, c0 + 1);
        chk1("release_valid", bus.blk_valid_o, 1'b0);
        tick();
        chk1("release_in_ready", bus.in_ready_o, 1'b1);

        // Reset mid-message discards 30 bytes
        send_msg(30, 2);
        rst_n = 1'b0;
        #1;
        chk1("midrst_in_ready", bus.in_ready_o, 1'b0);
        chk1("midrst_valid", bus.blk_valid_o, 1'b0);
        chkw("midrst_block", bus.block_o, 512'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk1("midrst_post_in_ready", bus.in_ready_o, 1'b1);
        push(ABC_BLK, 1'b1);
        send_abc();
        drain();
        repeat (3) tick();
        chk1("end_valid", bus.blk_valid_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
